// File: rtl/ntt_sequencer.sv
// ntt_sequencer: control FSM for an N-point Gentleman-Sande DIF NTT.
// It loads coefficients into RAM, issues every radix-2 butterfly stage by stage,
// and reads the results out in natural order by undoing the bit reversal.
// Latency: done is asserted 1 + N + LOGN*(N/2+BF_LAT) + N cycles after the start edge,
// assuming i_in_valid is held high during the load.
// Backpressure: none. i_in_valid low stalls the load. All other phases run
// without stalling, and i_start is ignored outside IDLE.
// Ports:
//   i_clk, i_rst (asynchronous, active-low), i_start, i_in_valid
//   o_load_we/o_load_addr                     : coefficient RAM write during LOAD
//   o_bf_valid/o_bf_addr_a/o_bf_addr_b/o_tw_idx : butterfly issue
//   o_wb_valid/o_wb_addr_a/o_wb_addr_b         : butterfly writeback, BF_LAT cycles after issue
//   o_out_valid/o_out_addr                     : readout RAM address
//   o_busy, o_done                             : status
module ntt_sequencer #(
  parameter int N      = 8,
  parameter int LOGN   = 3,
  parameter int BF_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_in_valid,
  output logic            o_load_we,
  output logic [LOGN-1:0] o_load_addr,
  output logic            o_bf_valid,
  output logic [LOGN-1:0] o_bf_addr_a,
  output logic [LOGN-1:0] o_bf_addr_b,
  output logic [LOGN-2:0] o_tw_idx,
  output logic            o_wb_valid,
  output logic [LOGN-1:0] o_wb_addr_a,
  output logic [LOGN-1:0] o_wb_addr_b,
  output logic            o_out_valid,
  output logic [LOGN-1:0] o_out_addr,
  output logic            o_busy,
  output logic            o_done
);

  localparam int SW = $clog2(LOGN);
  localparam int WW = $clog2(BF_LAT + 1);
  localparam int TW = LOGN - 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WAIT, S_OUT, S_DONE} state_t;

  typedef struct packed {
    logic            vld;
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
  } wb_t;

  state_t          r_state, w_next;
  logic [LOGN-1:0] r_cnt;
  logic [LOGN-1:0] r_k;
  logic [SW-1:0]   r_s;
  logic [WW-1:0]   r_wcnt;
  wb_t             r_pipe [BF_LAT];

  logic            w_load_last, w_calc_last, w_wait_last, w_out_last, w_stage_last;
  logic [LOGN-1:0] w_half, w_j, w_g, w_a, w_b, w_rev;
  logic [TW-1:0]   w_tw;

  assign w_load_last  = (r_cnt == LOGN'(N - 1));
  assign w_out_last   = (r_cnt == LOGN'(N - 1));
  assign w_calc_last  = (r_k == LOGN'(N / 2 - 1));
  assign w_wait_last  = (r_wcnt == WW'(BF_LAT - 1));
  assign w_stage_last = (r_s == SW'(LOGN - 1));

  // Butterfly k of stage s: the group is g = k / half, and the offset within the group is j = k mod half.
  // Because half is a power of two, the divide and the modulo reduce to a shift and a mask.
  assign w_half = LOGN'(N >> (32'(r_s) + 32'd1));
  assign w_j    = r_k & (w_half - 1'b1);
  assign w_g    = r_k >> (LOGN - 1 - 32'(r_s));
  assign w_a    = (w_g << (LOGN - 32'(r_s))) | w_j;
  assign w_b    = w_a + w_half;
  assign w_tw   = TW'(w_j << r_s);

  // The DIF result sits in bit-reversed order, so the readout address is the counter bit-reversed.
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < LOGN; i++) w_rev[i] = r_cnt[LOGN-1-i];
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_start) w_next = S_LOAD;
      S_LOAD: if (i_in_valid && w_load_last) w_next = S_CALC;
      S_CALC: if (w_calc_last) w_next = S_WAIT;
      S_WAIT: if (w_wait_last) w_next = w_stage_last ? S_OUT : S_CALC;
      S_OUT:  if (w_out_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_load_we   = 1'b0;
    o_load_addr = '0;
    o_bf_valid  = 1'b0;
    o_bf_addr_a = '0;
    o_bf_addr_b = '0;
    o_tw_idx    = '0;
    o_out_valid = 1'b0;
    o_out_addr  = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_LOAD: begin
        o_busy      = 1'b1;
        o_load_we   = i_in_valid;
        o_load_addr = r_cnt;
      end
      S_CALC: begin
        o_busy      = 1'b1;
        o_bf_valid  = 1'b1;
        o_bf_addr_a = w_a;
        o_bf_addr_b = w_b;
        o_tw_idx    = w_tw;
      end
      S_WAIT: o_busy = 1'b1;
      S_OUT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        o_out_addr  = w_rev;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters. Each counter is only advanced in the state that owns it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt  <= '0;
      r_k    <= '0;
      r_s    <= '0;
      r_wcnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (i_start) r_cnt <= '0;
        S_LOAD: begin
          if (i_in_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_load_last) begin
              r_s <= '0;
              r_k <= '0;
            end
          end
        end
        S_CALC: begin
          r_k <= r_k + 1'b1;
          if (w_calc_last) r_wcnt <= '0;
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (w_wait_last) begin
            if (!w_stage_last) begin
              r_s <= r_s + 1'b1;
              r_k <= '0;
            end else begin
              r_cnt <= '0;
            end
          end
        end
        S_OUT: r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // The writeback pipe free-runs regardless of state, so the last issue of a stage
  // always drains during WAIT. Only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < BF_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{vld: o_bf_valid, a: o_bf_addr_a, b: o_bf_addr_b};
      for (int i = 1; i < BF_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_wb_valid  = r_pipe[BF_LAT-1].vld;
  assign o_wb_addr_a = r_pipe[BF_LAT-1].a;
  assign o_wb_addr_b = r_pipe[BF_LAT-1].b;

endmodule
